// File: rtl/imem_boot_pkg.sv
// Shared types and defaults for the instruction-memory boot sequencer.
// Holds the sequencer state encoding, default geometry and the halt word.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    DONE
  } state_t;

  localparam int          AW_DEF        = 8;
  localparam logic [31:0] HALT_WORD_DEF = 32'h0000_006F;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/imem_port_mux.sv
// Combinational steering of the single memory port between host loader and CPU fetch.
// Zero latency; the CPU owns the port in RUN, the host only when host_en is high.
module imem_port_mux
  import imem_boot_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  state_t          state,
  input  logic            host_en,
  input  logic            host_valid,
  input  logic [AW-1:0]   host_addr,
  input  logic [31:0]     host_data,
  input  logic            cpu_fetch_req,
  input  logic [AW-1:0]   cpu_fetch_addr,
  output logic            cpu_fetch_gnt,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [31:0]     mem_wdata
);

  always_comb begin
    cpu_fetch_gnt = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (state == RUN) begin
      cpu_fetch_gnt = cpu_fetch_req;
      mem_en        = cpu_fetch_req;
      mem_addr      = cpu_fetch_addr;
    end else if (host_en && host_valid) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = host_addr;
      mem_wdata = host_data;
    end
  end

endmodule

// File: rtl/imem_boot_sched.sv
// Load/run/halt sequencer owning the instruction memory; fetch data one cycle after grant.
// Host is stalled (host_ready=0) outside IDLE/LOAD/DONE; IMEM_BOOT_WATCHDOG_EN adds a run-cycle timeout.
module imem_boot_sched
  import imem_boot_pkg::*;
#(
  parameter int          AW        = AW_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
`ifdef IMEM_BOOT_WATCHDOG_EN
  , parameter logic [31:0] MAX_CYCLES = 32'd100000
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            host_valid,
  output logic            host_ready,
  input  logic [AW-1:0]   host_addr,
  input  logic [31:0]     host_data,
  input  logic            host_last,
  input  logic            start,
  input  logic            cpu_fetch_req,
  input  logic [AW-1:0]   cpu_fetch_addr,
  output logic [31:0]     cpu_fetch_data,
  output logic            cpu_fetch_gnt,
  output logic            cpu_rst,
  output logic            cpu_run,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata,
  output logic            done,
  output logic [31:0]     run_cycles
`ifdef IMEM_BOOT_WATCHDOG_EN
  , output logic          timeout
`endif
);

  state_t      state_q, state_d;
  logic        loaded_q;
  logic        done_q;
  logic        rd_vld_q;
  logic [31:0] run_cycles_q;
  logic        host_en;
  logic        host_acc;
  logic        halt_hit;
  logic        wdog_hit;

  // Gated by reset so the loader sees host_ready=0 while reset is held.
  assign host_en  = reset && (state_q inside {IDLE, LOAD, DONE});
  assign host_acc = host_en && host_valid;
  assign halt_hit = (state_q == RUN) && rd_vld_q && (mem_rdata == HALT_WORD);

`ifdef IMEM_BOOT_WATCHDOG_EN
  logic timeout_q;
  assign wdog_hit = (state_q == RUN) && ((run_cycles_q + 32'd1) >= MAX_CYCLES);
  assign timeout  = timeout_q;
`else
  assign wdog_hit = 1'b0;
`endif

  imem_port_mux #(.AW(AW)) u_port_mux (
    .state          (state_q),
    .host_en        (host_en),
    .host_valid     (host_valid),
    .host_addr      (host_addr),
    .host_data      (host_data),
    .cpu_fetch_req  (cpu_fetch_req),
    .cpu_fetch_addr (cpu_fetch_addr),
    .cpu_fetch_gnt  (cpu_fetch_gnt),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cpu_rst = 1'b1;
    cpu_run = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host_acc)              state_d = host_last ? IDLE : LOAD;
        else if (start && loaded_q) state_d = ARM;
      end
      LOAD: begin
        if (host_acc && host_last) state_d = IDLE;
      end
      ARM: begin
        cpu_rst = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        cpu_rst = 1'b0;
        cpu_run = 1'b1;
        if (halt_hit || wdog_hit) state_d = DONE;
      end
      DONE: begin
        // Core stays out of reset so its result remains observable.
        cpu_rst = 1'b0;
        if (host_acc)   state_d = host_last ? IDLE : LOAD;
        else if (start) state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaded_q     <= 1'b0;
      done_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      rd_vld_q <= cpu_fetch_gnt;
      if (host_acc) loaded_q <= host_last;
      if (host_acc || state_q == ARM) done_q <= 1'b0;
      else if (halt_hit)              done_q <= 1'b1;
      if (state_q == ARM)      run_cycles_q <= '0;
      else if (state_q == RUN) run_cycles_q <= sat_inc32(run_cycles_q);
    end
  end

`ifdef IMEM_BOOT_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          timeout_q <= 1'b0;
    else if (host_acc || state_q == ARM) timeout_q <= 1'b0;
    else if (wdog_hit && !halt_hit)      timeout_q <= 1'b1;
  end
`endif

  assign host_ready     = host_en;
  assign done           = done_q;
  assign run_cycles     = run_cycles_q;
  assign cpu_fetch_data = rd_vld_q ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_imem_boot_sched.sv
// Randomized bench for imem_boot_sched with a word-array image model and a driven core-fetch model.
// Expected fetch data, done timing and run-cycle counts come from the image and fetch schedule.
module tb_imem_boot_sched;

  localparam int          AW   = 8;
  localparam logic [31:0] HALT = 32'h0000_006F;

  logic            clk = 1'b0;
  logic            reset;
  logic            host_valid, host_ready, host_last, start;
  logic [AW-1:0]   host_addr, cpu_fetch_addr, mem_addr;
  logic [31:0]     host_data, cpu_fetch_data, mem_wdata, mem_rdata, run_cycles;
  logic            cpu_fetch_req, cpu_fetch_gnt, cpu_rst, cpu_run;
  logic            mem_en, mem_we, done;

  always #5 clk = ~clk;

  imem_boot_sched dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_data(host_data), .host_last(host_last), .start(start),
    .cpu_fetch_req(cpu_fetch_req), .cpu_fetch_addr(cpu_fetch_addr),
    .cpu_fetch_data(cpu_fetch_data), .cpu_fetch_gnt(cpu_fetch_gnt),
    .cpu_rst(cpu_rst), .cpu_run(cpu_run),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .done(done), .run_cycles(run_cycles)
  );

  // Single-port synchronous RAM seen by the block.
  logic [31:0] ram [0:255];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  logic [31:0] img [0:255];
  int          q_a[$];
  logic [31:0] q_d[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] d;
    d = $urandom;
    while (d == HALT) d = $urandom;
    return d;
  endfunction

  // Program at 0..halt_a ending with the halt word, plus two stray writes high in memory.
  task automatic build_prog(input int halt_a, input bit shuffle);
    int j, ta;
    logic [31:0] td;
    q_a.delete();
    q_d.delete();
    for (int i = 0; i <= halt_a; i++) begin
      q_a.push_back(i);
      q_d.push_back((i == halt_a) ? HALT : rand_word());
    end
    for (int i = 0; i < 2; i++) begin
      q_a.push_back(int'($urandom_range(200, 64)));
      q_d.push_back(rand_word());
    end
    if (shuffle) begin
      for (int i = q_a.size() - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        ta = q_a[i]; q_a[i] = q_a[j]; q_a[j] = ta;
        td = q_d[i]; q_d[i] = q_d[j]; q_d[j] = td;
      end
    end
  endtask

  task automatic do_load(input int gap_pct);
    int a;
    logic [31:0] d;
    bit first;
    first = 1'b1;
    while (q_a.size() > 0) begin
      a = q_a.pop_front();
      d = q_d.pop_front();
      while (int'($urandom_range(99)) < gap_pct) begin
        host_valid = 1'b0;
        @(negedge clk);
        chk("gap_mem_en", mem_en, 1'b0);
        tick();
      end
      host_valid = 1'b1;
      host_addr  = a[AW-1:0];
      host_data  = d;
      host_last  = (q_a.size() == 0);
      @(negedge clk);
      chk("ld_ready", host_ready, 1'b1);
      chk("ld_we", mem_we, 1'b1);
      chk("ld_addr", mem_addr, a[AW-1:0]);
      chk("ld_wdata", mem_wdata, d);
      chk("ld_cpu_run", cpu_run, 1'b0);
      if (!first) chk("ld_cpu_rst", cpu_rst, 1'b1);
      img[a] = d;
      first = 1'b0;
      tick();
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
  endtask

  // Pulse start, then act as a core fetching sequentially until the halt word returns.
  task automatic run_prog(input int halt_a, input int req_pct, input bit hold_host, input int abort_i);
    int pc, ih, pa;
    bit pg, req, fin;
    logic [AW-1:0] ha;
    logic [31:0]   hd;
    ha = '0;
    hd = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (hold_host) begin
      ha = AW'($urandom_range(255, 210));
      hd = rand_word();
      host_valid = 1'b1; host_addr = ha; host_data = hd; host_last = 1'b1;
    end
    @(negedge clk);
    chk("arm_cpu_rst", cpu_rst, 1'b0);
    chk("arm_cpu_run", cpu_run, 1'b0);
    chk("arm_host_ready", host_ready, 1'b0);
    chk("arm_mem_en", mem_en, 1'b0);
    tick();
    pc = 0; ih = -1; pa = 0; pg = 1'b0; fin = 1'b0;
    for (int i = 0; i < 300 && !fin; i++) begin
      req = (int'($urandom_range(99)) < req_pct);
      cpu_fetch_req  = req;
      cpu_fetch_addr = pc[AW-1:0];
      if (i == abort_i) begin
        reset = 1'b0;
        #1;
        chk("rst_run_cpu_rst", cpu_rst, 1'b1);
        chk("rst_run_cpu_run", cpu_run, 1'b0);
        chk("rst_run_gnt", cpu_fetch_gnt, 1'b0);
        chk("rst_run_mem_en", mem_en, 1'b0);
        chk("rst_run_host_ready", host_ready, 1'b0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        chk("rst_run_fetch_data", cpu_fetch_data, 32'd0);
        chk("rst_run_done", done, 1'b0);
        cpu_fetch_req = 1'b0;
        host_valid    = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        return;
      end
      @(negedge clk);
      chk("run_cpu_run", cpu_run, 1'b1);
      chk("run_cpu_rst", cpu_rst, 1'b0);
      chk("run_host_ready", host_ready, 1'b0);
      chk("run_gnt", cpu_fetch_gnt, req);
      chk("run_mem_en", mem_en, req);
      chk("run_mem_we", mem_we, 1'b0);
      chk("run_cycles", run_cycles, i);
      if (pg) chk("fetch_data", cpu_fetch_data, img[pa]);
      if (ih >= 0) fin = 1'b1;
      else if (req) begin
        pg = 1'b1;
        pa = pc;
        if (pc == halt_a) ih = i;
        else pc++;
      end else pg = 1'b0;
      tick();
    end
    cpu_fetch_req = 1'b0;
    if (!fin) chk("run_bound", 32'd0, 32'd1);
    @(negedge clk);
    chk("halt_done", done, 1'b1);
    chk("halt_cpu_run", cpu_run, 1'b0);
    chk("halt_cpu_rst", cpu_rst, 1'b0);
    chk("halt_run_cycles", run_cycles, ih + 2);
    chk("halt_gnt", cpu_fetch_gnt, 1'b0);
    if (hold_host) begin
      chk("held_ready", host_ready, 1'b1);
      chk("held_we", mem_we, 1'b1);
      chk("held_addr", mem_addr, ha);
      chk("held_wdata", mem_wdata, hd);
      img[ha] = hd;
      tick();
      host_valid = 1'b0;
      host_last  = 1'b0;
      @(negedge clk);
      chk("held_post_cpu_rst", cpu_rst, 1'b1);
      chk("held_post_done", done, 1'b0);
    end
    tick();
  endtask

  // In DONE: host and start together; host must win.
  task automatic done_host_start();
    logic [AW-1:0] a;
    logic [31:0]   d;
    a = AW'($urandom_range(255, 210));
    d = rand_word();
    host_valid = 1'b1; start = 1'b1; host_addr = a; host_data = d; host_last = 1'b0;
    @(negedge clk);
    chk("dhs_ready", host_ready, 1'b1);
    chk("dhs_we", mem_we, 1'b1);
    chk("dhs_addr", mem_addr, a);
    chk("dhs_done_before", done, 1'b1);
    img[a] = d;
    tick();
    start = 1'b0;
    a = a + AW'(1);
    d = rand_word();
    host_addr = a; host_data = d; host_last = 1'b1;
    @(negedge clk);
    chk("dhs_load_cpu_rst", cpu_rst, 1'b1);
    chk("dhs_load_done", done, 1'b0);
    chk("dhs_load_we", mem_we, 1'b1);
    img[a] = d;
    tick();
    host_valid = 1'b0;
    host_last  = 1'b0;
    @(negedge clk);
    chk("dhs_idle_cpu_rst", cpu_rst, 1'b1);
    chk("dhs_idle_cpu_run", cpu_run, 1'b0);
    tick();
  endtask

  int halt_a;

  initial begin
    reset = 1'b0;
    host_valid = 1'b1; host_addr = '0; host_data = '0; host_last = 1'b0;
    start = 1'b0; cpu_fetch_req = 1'b1; cpu_fetch_addr = '0;
    for (int i = 0; i < 256; i++) img[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_host_ready", host_ready, 1'b0);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_cpu_run", cpu_run, 1'b0);
    chk("rst_gnt", cpu_fetch_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_run_cycles", run_cycles, 32'd0);
    chk("rst_fetch_data", cpu_fetch_data, 32'd0);
    host_valid = 1'b0;
    cpu_fetch_req = 1'b0;
    reset = 1'b1;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("noload_cpu_rst", cpu_rst, 1'b1);
    chk("noload_cpu_run", cpu_run, 1'b0);
    tick();

    build_prog(3, 1'b0);
    do_load(0);
    @(negedge clk);
    chk("loaded_idle_cpu_rst", cpu_rst, 1'b1);
    chk("loaded_idle_ready", host_ready, 1'b1);
    tick();
    run_prog(3, 100, 1'b0, -1);
    done_host_start();

    halt_a = 3;
    for (int it = 0; it < 6; it++) begin
      halt_a = int'($urandom_range(12, 1));
      build_prog(halt_a, 1'b1);
      do_load(30);
      run_prog(halt_a, int'($urandom_range(100, 40)), it[0], -1);
      if (!it[0]) run_prog(halt_a, 70, 1'b0, -1);
    end

    run_prog(halt_a, 80, 1'b0, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_start_cpu_rst", cpu_rst, 1'b1);
    chk("post_rst_start_cpu_run", cpu_run, 1'b0);
    tick();
    q_a.delete();
    q_d.delete();
    q_a.push_back(250);
    q_d.push_back(rand_word());
    do_load(0);
    run_prog(halt_a, 90, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
